// File: rtl/adc_display_sequencer.sv
// rtl/adc_display_sequencer.sv - channel select, binary-to-BCD engine and tear-free display registers
// Auto-scan channel rotation is built only when ADC_DISP_AUTOSCAN_EN is defined.
module adc_display_sequencer #(
  parameter int NUM_CH         = 3,
  parameter int DWELL_CYCLES   = 100_000_000,
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int CH_W           = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH_W-1:0]       ch_select,
  input  logic [1:0]            fmt_select,
  input  logic                  scan_en,
  input  logic [16*NUM_CH-1:0]  raw_bus,
  input  logic [16*NUM_CH-1:0]  avg_bus,
  input  logic [16*NUM_CH-1:0]  mv_bus,
  output logic [3:0]            dig0,
  output logic [3:0]            dig1,
  output logic [3:0]            dig2,
  output logic [3:0]            dig3,
  output logic [3:0]            dp_vec,
  output logic [3:0]            blank_vec,
  output logic [NUM_CH-1:0]     ch_enable,
  output logic [CH_W-1:0]       active_ch,
  output logic                  ovf,
  output logic                  update_strobe
);

  typedef enum logic [1:0] {IDLE, LATCH, CONVERT, LOAD} state_t;

  state_t      state, state_next;
  logic        take, snap, shift, load_en;
  logic        pending, req;
  logic [31:0] refresh_cnt;
  logic        refresh_hit;
  logic [CH_W-1:0] active_prev;
  logic [1:0]  fmt_q, fmt_prev, fmt_snap;
  logic [15:0] raw_snap, avg_snap, bin_r;
  logic [19:0] bcd_r, bcd_next;
  logic [3:0]  bit_cnt;
  logic        ch_valid;

  assign ch_valid = (32'(ch_select) < NUM_CH);

`ifdef ADC_DISP_AUTOSCAN_EN
  logic [31:0] dwell_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_ch <= '0;
      dwell_cnt <= '0;
    end else if (scan_en) begin
      if (dwell_cnt == 32'(DWELL_CYCLES - 1)) begin
        dwell_cnt <= '0;
        active_ch <= (active_ch == CH_W'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 32'd1;
      end
    end else begin
      dwell_cnt <= '0;
      if (ch_valid) active_ch <= ch_select;
    end
  end
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        active_ch <= '0;
    else if (ch_valid) active_ch <= ch_select;
  end
`endif

  // Any change is seen one clock after it lands in its register.
  assign refresh_hit = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
  assign req = refresh_hit || (active_ch != active_prev) || (fmt_q != fmt_prev);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= 1'b1;
      refresh_cnt <= '0;
      active_prev <= '0;
      fmt_q       <= '0;
      fmt_prev    <= '0;
      ch_enable   <= '0;
      state       <= IDLE;
    end else begin
      pending     <= req || (pending && !take);
      refresh_cnt <= refresh_hit ? '0 : refresh_cnt + 32'd1;
      active_prev <= active_ch;
      fmt_q       <= fmt_select;
      fmt_prev    <= fmt_q;
      ch_enable   <= NUM_CH'(1) << active_ch;
      state       <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    snap       = 1'b0;
    shift      = 1'b0;
    load_en    = 1'b0;
    case (state)
      IDLE: if (pending) begin
        take       = 1'b1;
        state_next = LATCH;
      end
      LATCH: begin
        snap       = 1'b1;
        state_next = CONVERT;
      end
      CONVERT: begin
        shift = 1'b1;
        if (bit_cnt == 4'hF) begin
          load_en    = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  function automatic logic [19:0] bcd_step(input logic [19:0] b, input logic bit_in);
    logic [19:0] a;
    a = b;
    for (int i = 0; i < 5; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[18:0], bit_in};
  endfunction

  assign bcd_next = bcd_step(bcd_r, bin_r[15]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_snap <= '0;
      avg_snap <= '0;
      bin_r    <= '0;
      bcd_r    <= '0;
      fmt_snap <= '0;
      bit_cnt  <= '0;
    end else if (snap) begin
      raw_snap <= raw_bus[16*active_ch +: 16];
      avg_snap <= avg_bus[16*active_ch +: 16];
      bin_r    <= mv_bus[16*active_ch +: 16];
      fmt_snap <= fmt_q;
      bcd_r    <= '0;
      bit_cnt  <= '0;
    end else if (shift) begin
      bcd_r    <= bcd_next;
      bin_r    <= {bin_r[14:0], 1'b0};
      bit_cnt  <= bit_cnt + 4'd1;
    end
  end

  logic        dec_ovf;
  logic [15:0] dec_digits, nxt_digits;
  logic [3:0]  nxt_dp, nxt_blank;
  logic        nxt_ovf, z3, z32, z321;

  always_comb begin
    dec_ovf    = (bcd_next[19:16] != 4'd0);
    dec_digits = dec_ovf ? 16'h9999 : bcd_next[15:0];
    z3         = (dec_digits[15:12] == 4'd0);
    z32        = z3  && (dec_digits[11:8] == 4'd0);
    z321       = z32 && (dec_digits[7:4] == 4'd0);
    nxt_digits = avg_snap;
    nxt_dp     = 4'b0000;
    nxt_blank  = 4'b0000;
    nxt_ovf    = 1'b0;
    case (fmt_snap)
      2'b00: nxt_digits = avg_snap;
      2'b10: nxt_digits = raw_snap;
      2'b01: begin
        nxt_digits = dec_digits;
        nxt_ovf    = dec_ovf;
        nxt_blank  = {z3, z32, z321, 1'b0};
      end
      default: begin
        nxt_digits = dec_digits;
        nxt_ovf    = dec_ovf;
        nxt_dp     = 4'b1000;
      end
    endcase
  end

  // Display registers move together only on the final conversion step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {dig3, dig2, dig1, dig0} <= '0;
      dp_vec        <= '0;
      blank_vec     <= '0;
      ovf           <= 1'b0;
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= load_en;
      if (load_en) begin
        {dig3, dig2, dig1, dig0} <= nxt_digits;
        dp_vec    <= nxt_dp;
        blank_vec <= nxt_blank;
        ovf       <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adc_display_sequencer.sv
// tb/tb_adc_display_sequencer.sv - model-checked bench for adc_display_sequencer
module tb_adc_display_sequencer;
  localparam int NUM_CH = 3, CH_W = 2, DWELL = 50, REFRESH = 200;

  logic clk = 1'b0, reset = 1'b0;
  logic [CH_W-1:0] ch_select = '0;
  logic [1:0] fmt_select = 2'b01;
  logic scan_en = 1'b0;
  logic [16*NUM_CH-1:0] raw_bus = '0, avg_bus = '0, mv_bus = '0;
  logic [3:0] dig0, dig1, dig2, dig3, dp_vec, blank_vec;
  logic [NUM_CH-1:0] ch_enable;
  logic [CH_W-1:0] active_ch;
  logic ovf, update_strobe;

  always #5 clk = ~clk;

  adc_display_sequencer #(.NUM_CH(NUM_CH), .DWELL_CYCLES(DWELL), .REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .reset(reset), .ch_select(ch_select), .fmt_select(fmt_select), .scan_en(scan_en),
    .raw_bus(raw_bus), .avg_bus(avg_bus), .mv_bus(mv_bus),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dp_vec(dp_vec), .blank_vec(blank_vec),
    .ch_enable(ch_enable), .active_ch(active_ch), .ovf(ovf), .update_strobe(update_strobe));

  int tests = 0, fails = 0;

  // Model: pass_t counts clocks since a display pass was accepted (-1 when none running).
  int k, pass_t, m_act, m_fmt, dw;
  bit pend, act_chg, fmt_chg;
  logic [15:0] s_raw, s_avg, s_mv;
  logic [1:0] s_fmt;
  logic [15:0] e_dig;
  logic [3:0] e_dp, e_blank;
  logic e_ovf, e_str;
  logic [NUM_CH-1:0] e_chen;

  task automatic model_reset();
    k = 0; pass_t = -1; m_act = 0; m_fmt = 0; dw = 0;
    pend = 1'b1; act_chg = 1'b0; fmt_chg = 1'b0;
    s_raw = '0; s_avg = '0; s_mv = '0; s_fmt = '0;
    e_dig = '0; e_dp = '0; e_blank = '0; e_ovf = 1'b0; e_str = 1'b0; e_chen = '0;
  endtask

  task automatic model_load();
    int v;
    e_dp = 4'b0000; e_blank = 4'b0000; e_ovf = 1'b0;
    if (!s_fmt[0]) e_dig = s_fmt[1] ? s_raw : s_avg;
    else begin
      v = int'(s_mv);
      if (v > 9999) begin v = 9999; e_ovf = 1'b1; end
      e_dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      if (s_fmt[1]) e_dp = 4'b1000;
      else e_blank = {v < 1000, v < 100, v < 10, 1'b0};
    end
  endtask

  task automatic model_step();
    bit ev;
    int nxt;
    k++;
    ev = (k % REFRESH == 0) || act_chg || fmt_chg;
    if (pass_t < 0) begin
      if (pend) pass_t = 0;
      pend = ev;
    end else begin
      pend = pend || ev;
      pass_t++;
      if (pass_t == 1) begin
        s_raw = raw_bus[16*m_act +: 16]; s_avg = avg_bus[16*m_act +: 16];
        s_mv = mv_bus[16*m_act +: 16]; s_fmt = 2'(m_fmt);
      end
      if (pass_t == 17) begin model_load(); e_str = 1'b1; end
      if (pass_t == 18) begin e_str = 1'b0; pass_t = -1; end
    end
    e_chen = NUM_CH'(1) << m_act;
    nxt = m_act;
`ifdef ADC_DISP_AUTOSCAN_EN
    if (scan_en) begin
      dw++;
      if (dw == DWELL) begin dw = 0; nxt = (m_act + 1) % NUM_CH; end
    end else begin
      dw = 0;
      if (int'(ch_select) < NUM_CH) nxt = int'(ch_select);
    end
`else
    if (int'(ch_select) < NUM_CH) nxt = int'(ch_select);
`endif
    act_chg = (nxt != m_act); m_act = nxt;
    fmt_chg = (int'(fmt_select) != m_fmt); m_fmt = int'(fmt_select);
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin : cmp
    logic [30:0] a, e;
    a = {dig3, dig2, dig1, dig0, dp_vec, blank_vec, ovf, update_strobe, active_ch, ch_enable};
    e = {e_dig, e_dp, e_blank, e_ovf, e_str, CH_W'(m_act), e_chen};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (3) tick();
    while ((pass_t >= 0 || pend) && n < 300) begin tick(); n++; end
    if (n >= 300) begin tests++; fails++; $display("FAIL settle_timeout actual=%0d required<300", n); end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin tick(); n++; end while (!update_strobe && n < 60);
    if (!update_strobe) begin tests++; fails++; $display("FAIL strobe_timeout actual=%0d required<60", n); end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] raw, input logic [15:0] avg, input logic [15:0] mv);
    raw_bus[16*ch +: 16] = raw; avg_bus[16*ch +: 16] = avg; mv_bus[16*ch +: 16] = mv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_ch(0, 16'h0123, 16'h1111, 16'd1234);
    set_ch(2, 16'h0222, 16'h2222, 16'd777);
    repeat (3) tick();
    check("reset_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
    check("reset_misc", {dp_vec, blank_vec, ovf, update_strobe, active_ch, ch_enable}, 0);

    reset = 1'b1;
    wait_strobe(n);
    check("release_strobe_cycle", n + 1, 19);
    check("ch0_mv_digits", {dig3, dig2, dig1, dig0}, 16'h1234);
    check("ch0_blank", blank_vec, 4'b0000);
    check("ch0_enable", ch_enable, 3'b001);
    settle();

    set_ch(1, 16'h0000, 16'h0000, 16'd42);
    ch_select = 2'd1; settle();
    check("ch1_42_digits", {dig3, dig2, dig1, dig0}, 16'h0042);
    check("ch1_42_blank", blank_vec, 4'b1100);
    check("ch1_42_dp", dp_vec, 4'b0000);
    fmt_select = 2'b11; settle();
    check("volts_dp", dp_vec, 4'b1000);
    check("volts_blank", blank_vec, 4'b0000);

    set_ch(1, 16'h0ABC, 16'h0000, 16'd12000);
    fmt_select = 2'b01; settle();
    check("ovf_digits", {dig3, dig2, dig1, dig0}, 16'h9999);
    check("ovf_flag", ovf, 1'b1);
    fmt_select = 2'b10; settle();
    check("raw_hex_digits", {dig3, dig2, dig1, dig0}, 16'h0ABC);
    check("raw_hex_ovf", ovf, 1'b0);

    ch_select = 2'd0; settle();
    fmt_select = 2'b00;
    repeat (6) tick();
    ch_select = 2'd2;
    wait_strobe(n);
    check("first_pass_old_ch", {dig3, dig2, dig1, dig0}, 16'h1111);
    wait_strobe(n);
    check("extra_pass_gap", n, 19);
    check("extra_pass_new_ch", {dig3, dig2, dig1, dig0}, 16'h2222);
    ch_select = 2'd3; repeat (3) tick();
    check("invalid_sel_holds", active_ch, 2'd2);

    ch_select = 2'd0; settle();
    fmt_select = 2'b01;
    repeat (8) tick();
    reset = 1'b0; #1;
    check("midconv_reset_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
    check("midconv_reset_misc", {dp_vec, blank_vec, ovf, update_strobe, active_ch, ch_enable}, 0);
    repeat (3) begin tick(); check("reset_no_strobe", update_strobe, 1'b0); end
    reset = 1'b1;
    wait_strobe(n);
    check("rerelease_strobe_cycle", n + 1, 19);
    check("rerelease_digits", {dig3, dig2, dig1, dig0}, 16'h1234);
    settle();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) ch_select = CH_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) fmt_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 9) == 0)
        set_ch(int'($urandom_range(0, NUM_CH - 1)), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 20000)));
      tick();
    end
    scan_en = 1'b0; ch_select = 2'd0; settle();

`ifdef ADC_DISP_AUTOSCAN_EN
    scan_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      n = 0;
      do begin tick(); n++; end while (active_ch == CH_W'((c - 1) % NUM_CH) && n < 200);
      check("scan_dwell", n, DWELL);
      check("scan_ch", active_ch, CH_W'(c % NUM_CH));
    end
    ch_select = 2'd1; scan_en = 1'b0; tick();
    check("scan_drop", active_ch, 2'd1);
    settle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_display_sequencer.md
# adc_display_sequencer

Parametrised successor to the three-way ADC display mux. It selects one of `NUM_CH` ADC channels, either by switch or by a timed auto-scan, and snapshots that channel's raw, averaged and mV words. It converts the selected word through an iterative binary-to-BCD engine and drives tear-free registered digits to `seven_segment_display_subsystem`, including decimal-point and leading-zero-blank vectors. It sits between the ADC front ends (XADC, PWM, R2R, future channels) and the display.

## Interface
- `NUM_CH`, 3: number of ADC channels; 2..8.
- `DWELL_CYCLES`, 100_000_000: clocks per channel in auto-scan (1 s at 100 MHz).
- `REFRESH_CYCLES`, 10_000_000: clocks between periodic display refreshes.
- `CH_W`, $clog2(NUM_CH): channel index width.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ch_select`  in  CH_W  manual channel index.
- `fmt_select`  in  2  00=avg hex, 01=mV decimal (blanked), 10=raw hex, 11=volts decimal.
- `scan_en`  in  1  auto-scan request.
- `raw_bus`  in  16*NUM_CH  raw words; channel k at [16k+15:16k].
- `avg_bus`  in  16*NUM_CH  averaged words, same packing.
- `mv_bus`  in  16*NUM_CH  scaled mV words, same packing.
- `dig0..dig3`  out  4 each  display nibbles; dig3 = most significant.
- `dp_vec`  out  4  decimal points; bit3 = dig3.
- `blank_vec`  out  4  per-digit blank; bit3 = dig3.
- `ch_enable`  out  NUM_CH  one-hot enable for the active channel's converter.
- `active_ch`  out  CH_W  channel currently shown.
- `ovf`  out  1  decimal value > 9999, display saturated.
- `update_strobe`  out  1  one-cycle pulse when the display registers load.

## Operation
- Channel select: `active_ch` follows `ch_select` when scan is off. If `ch_select` ≥ NUM_CH, `active_ch` holds its value. `ch_enable` = one-hot(`active_ch`), registered.
- Refresh request is set by any of: reset release, change of `active_ch`, change of `fmt_select`, or expiry of the refresh counter. It is a sticky pending flag.
- FSM states:
  - IDLE: go to LATCH when pending is set; pending clears.
  - LATCH: snapshot the three words of `active_ch` and the format, one cycle.
  - CONVERT: 16-cycle shift-add-3 on the snapshot mV word. It always runs, so latency is uniform across formats.
  - LOAD: write outputs and pulse `update_strobe`, then go to IDLE.
- Requests arriving during LATCH, CONVERT or LOAD set pending. The current pass completes with its old snapshot, then one extra pass runs.
- Formats:
  - Hex (00, 10): nibbles of the avg or raw word; `dp_vec` = 0000; `blank_vec` = 0000.
  - 01: BCD of mV. Leading zeros are blanked in dig3..dig1; dig0 is never blanked. `dp_vec` = 0000.
  - 11: BCD of mV shown as V.mmm. `dp_vec` = 1000; `blank_vec` = 0000.
- Decimal overflow: if mV > 9999, digits = 9,9,9,9 and `ovf` = 1; otherwise `ovf` = 0. In hex formats `ovf` = 0.

## Timing
- Reset state:
  - digits = 0, `dp_vec` = 0000, `blank_vec` = 0000, `ovf` = 0, `update_strobe` = 0.
  - `active_ch` = 0, `ch_enable` = 0, FSM = IDLE, pending = 1, counters = 0.
- Latency: an input change sampled at edge N causes the pending set at N+1, LATCH at N+2, CONVERT at N+3..N+18, and LOAD at N+19. New outputs are valid after edge N+19.
- Outputs change only at LOAD; between loads they are stable.
- The refresh counter wraps at REFRESH_CYCLES−1 and issues one request per wrap.
- Reset asserted mid-CONVERT clears everything immediately; no strobe is produced.

## Configuration
- `ADC_DISP_AUTOSCAN_EN` defined:
  - When `scan_en` = 1, `ch_select` is ignored.
  - `active_ch` advances every DWELL_CYCLES, wrapping NUM_CH−1 → 0.
  - On `scan_en` falling, `active_ch` returns to a valid `ch_select` on the next clock and the dwell counter clears.
- Not defined: `scan_en` is ignored, no dwell counter is built, and selection is manual only.

## Test plan
- Reset release, NUM_CH=3, ch 0 mv=1234, fmt=01 -> `update_strobe` at cycle 19; digits 1,2,3,4; `blank_vec`=0000; `ch_enable`=001.
- ch 1 mv=0042, fmt 01 -> digits 0,0,4,2 with `blank_vec`=1100. Switch fmt to 11 -> `dp_vec`=1000, `blank_vec`=0000.
- mv=12000, fmt 01 -> digits 9999, `ovf`=1. Switch fmt to 10 with raw=0x0ABC -> digits 0,A,B,C, `ovf`=0.
- Change `ch_select` 0→2 during CONVERT -> first strobe shows ch 0 data, second strobe ~20 cycles later shows ch 2; `ch_select`=3 -> `active_ch` holds.
- With `ADC_DISP_AUTOSCAN_EN` defined, DWELL_CYCLES=50, `scan_en`=1 -> `active_ch` sequence 0,1,2,0 at 50-cycle spacing. Drop `scan_en` with `ch_select`=1 -> `active_ch`=1 next cycle.
- Assert reset mid-CONVERT -> all outputs at reset values, no strobe; after release, one refresh completes at cycle 19.
